// File: rtl/aes_seq_pkg.sv
// Shared types and sizes for the AES-128 decryption block sequencer.
// Imported by the byte shifter and the sequencer top.
package aes_seq_pkg;

  localparam int BYTES_PER_BLOCK = 16;
  localparam int BLOCK_W         = 128;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    START   = 2'd1,
    WAIT    = 2'd2,
    EMIT    = 2'd3
  } seq_state_e;

endpackage

// File: rtl/aes_byte_shifter.sv
// 128-bit register with parallel load and byte-wide shift-left.
// A shift-in pushes byte_in into [7:0]; a shift-out pushes zeros.
module aes_byte_shifter
  import aes_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [BLOCK_W-1:0] load_data,
  input  logic               shift_in,
  input  logic [7:0]         byte_in,
  input  logic               shift_out,
  output logic [BLOCK_W-1:0] data
);

  logic [BLOCK_W-1:0] data_reg;
  logic [BLOCK_W-1:0] shifted;

  // Each byte lane takes the lane below it; lane 0 is the entry point.
  genvar gi;
  generate
    for (gi = 1; gi < BYTES_PER_BLOCK; gi++) begin : g_lane
      assign shifted[8*gi +: 8] = data_reg[8*(gi-1) +: 8];
    end
  endgenerate
  assign shifted[7:0] = shift_in ? byte_in : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= load_data;
    end else if (shift_in || shift_out) begin
      data_reg <= shifted;
    end
  end

  assign data = data_reg;

endmodule

// File: rtl/aes_dec_block_sequencer.sv
// Feeds 16-byte ciphertext blocks into the AES-128 decryption core and
// serialises the resulting plaintext back out, counting blocks per sector.
module aes_dec_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int BLOCKS_PER_SECTOR = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic               key_load,
  output logic               key_err,
  output logic [BLOCK_W-1:0] aes_text,
  output logic [BLOCK_W-1:0] aes_key,
  output logic               aes_decrypt,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_dout,
  output logic               busy,
  output logic               sector_done
);

  localparam int SEC_W = (BLOCKS_PER_SECTOR > 1) ? $clog2(BLOCKS_PER_SECTOR) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(BLOCKS_PER_SECTOR - 1);

  seq_state_e         state_reg;
  logic [3:0]         byte_cnt_reg;
  logic [SEC_W-1:0]   sec_cnt_reg;
  logic               done_q_reg;
  logic               in_ready_reg;
  logic               aes_decrypt_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic               key_err_reg;
  logic               sector_done_reg;
  logic [BLOCK_W-1:0] aes_key_reg;
  logic [BLOCK_W-1:0] out_block;

  logic in_fire;
  logic out_fire;
  logic last_byte;
  logic done_rise;
  logic capture;
  logic key_ok;

  assign in_fire   = in_valid && in_ready_reg && (state_reg == COLLECT);
  assign out_fire  = out_valid_reg && out_ready;
  assign last_byte = (byte_cnt_reg == 4'd15);
  // Only a fresh edge counts, so a done level left over from the last block is ignored.
  assign done_rise = aes_done && !done_q_reg;
  assign capture   = (state_reg == WAIT) && done_rise;
  assign key_ok    = (state_reg == COLLECT) && (byte_cnt_reg == 4'd0) && !in_fire;

  aes_byte_shifter u_in_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_in  (in_fire),
    .byte_in   (in_data),
    .shift_out (1'b0),
    .data      (aes_text)
  );

  aes_byte_shifter u_out_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (capture),
    .load_data (aes_dout),
    .shift_in  (1'b0),
    .byte_in   (8'h00),
    .shift_out (out_fire),
    .data      (out_block)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= COLLECT;
      byte_cnt_reg    <= '0;
      sec_cnt_reg     <= '0;
      done_q_reg      <= 1'b0;
      in_ready_reg    <= 1'b0;
      aes_decrypt_reg <= 1'b0;
      out_valid_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      key_err_reg     <= 1'b0;
      sector_done_reg <= 1'b0;
      aes_key_reg     <= '0;
    end else begin
      aes_decrypt_reg <= 1'b0;
      key_err_reg     <= 1'b0;
      sector_done_reg <= 1'b0;
      done_q_reg      <= aes_done;

      if (key_load) begin
        if (key_ok) aes_key_reg <= key_in;
        else        key_err_reg <= 1'b1;
      end

      case (state_reg)
        COLLECT: begin
          in_ready_reg <= 1'b1;
          if (in_fire) begin
            if (last_byte) begin
              byte_cnt_reg    <= '0;
              state_reg       <= START;
              in_ready_reg    <= 1'b0;
              aes_decrypt_reg <= 1'b1;
              busy_reg        <= 1'b1;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 4'd1;
            end
          end
        end
        START: begin
          state_reg <= WAIT;
        end
        WAIT: begin
          if (done_rise) begin
            state_reg     <= EMIT;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        EMIT: begin
          if (out_fire) begin
            if (last_byte) begin
              byte_cnt_reg  <= '0;
              state_reg     <= COLLECT;
              out_valid_reg <= 1'b0;
              in_ready_reg  <= 1'b1;
              if (sec_cnt_reg == SEC_LAST) begin
                sec_cnt_reg     <= '0;
                sector_done_reg <= 1'b1;
              end else begin
                sec_cnt_reg <= sec_cnt_reg + 1'b1;
              end
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 4'd1;
            end
          end
        end
        default: state_reg <= COLLECT;
      endcase
    end
  end

  assign in_ready    = in_ready_reg;
  assign out_valid   = out_valid_reg;
  assign out_data    = out_block[BLOCK_W-1 -: 8];
  assign aes_key     = aes_key_reg;
  assign aes_decrypt = aes_decrypt_reg;
  assign busy        = busy_reg;
  assign key_err     = key_err_reg;
  assign sector_done = sector_done_reg;

endmodule

// File: tb/tb_aes_dec_block_sequencer.sv
// Scoreboard bench for aes_dec_block_sequencer with a simple core model
// that returns the bitwise inverse of the ciphertext.
module tb_aes_dec_block_sequencer;

  localparam int BPS = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         key_err;
  logic [127:0] aes_text;
  logic [127:0] aes_key;
  logic         aes_decrypt;
  logic         aes_done = 1'b0;
  logic [127:0] aes_dout = '0;
  logic         busy;
  logic         sector_done;

  always #5 clk = ~clk;

  aes_dec_block_sequencer #(.BLOCKS_PER_SECTOR(BPS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .key_in      (key_in),
    .key_load    (key_load),
    .key_err     (key_err),
    .aes_text    (aes_text),
    .aes_key     (aes_key),
    .aes_decrypt (aes_decrypt),
    .aes_done    (aes_done),
    .aes_dout    (aes_dout),
    .busy        (busy),
    .sector_done (sector_done)
  );

  int total = 0;
  int bad = 0;
  logic [7:0]   exp_q[$];
  logic [127:0] text_q[$];
  int dec_cnt = 0;
  int sd_cnt = 0;
  int sec_bytes = 0;
  int out_bytes = 0;
  bit core_auto = 1'b1;
  int core_lat = 50;
  bit toggle = 1'b0;
  bit gap = 1'b0;
  logic [127:0] key_model = '0;
  logic prev_stall = 1'b0;
  logic prev_dec = 1'b0;
  logic [7:0] prev_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard monitor: pops expected bytes/blocks whenever the DUT presents them.
  initial begin
    logic [7:0]   e;
    logic [127:0] t;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        prev_dec   = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, prev_data);
        end
        if (out_valid) chk("no_input_in_emit", in_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_out actual=%h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            chk("out_byte", out_data, e);
            out_bytes++;
            sec_bytes++;
            if (out_bytes % 16 == 0) $display("block out #%0d done", out_bytes / 16);
          end
        end
        if (aes_decrypt) begin
          dec_cnt++;
          chk("decrypt_one_cycle", prev_dec, 0);
          chk("busy_at_start", busy, 1);
          if (text_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_decrypt actual=%h required=none", aes_text);
          end else begin
            t = text_q.pop_front();
            chk("aes_text", aes_text, t);
          end
        end
        if (sector_done) begin
          sd_cnt++;
          chk("sector_done_at_512", sec_bytes, 512);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_dec   = aes_decrypt;
      end
    end
  end

  // Core model: plaintext = ~ciphertext, one-cycle done after core_lat cycles.
  initial begin
    logic [127:0] t;
    forever begin
      @(negedge clk);
      if (core_auto && aes_decrypt && !rst) begin
        t = aes_text;
        repeat (core_lat) @(posedge clk);
        #1;
        aes_dout = ~t;
        aes_done = 1'b1;
        @(posedge clk);
        #1;
        aes_done = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = toggle ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mk_block(input logic [7:0] base);
    logic [127:0] b;
    for (int i = 0; i < 16; i++) b[127-8*i -: 8] = base + 8'(i);
    return b;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL in_accept_timeout actual=stalled required=accepted");
    end
  endtask

  task automatic push_block(input logic [127:0] blk, input bit push_out);
    text_q.push_back(blk);
    if (push_out)
      for (int i = 0; i < 16; i++) exp_q.push_back(~blk[127-8*i -: 8]);
  endtask

  task automatic send_range(input logic [127:0] blk, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (gap && (i % 3 == 1)) begin
        @(posedge clk);
        #1;
      end
      send_byte(blk[127-8*i -: 8]);
    end
  endtask

  task automatic send_block(input logic [127:0] blk, input bit push_out);
    push_block(blk, push_out);
    send_range(blk, 0, 15);
    $display("block in %h", blk);
  endtask

  task automatic drain();
    for (int n = 0; n < 3000 && exp_q.size() > 0; n++) @(posedge clk);
    chk("drain_complete", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_dec();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (aes_decrypt) ok = 1'b1;
    end
    chk("decrypt_seen", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_key(input logic [127:0] k, input bit ok_exp);
    key_in   = k;
    key_load = 1'b1;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    if (ok_exp) key_model = k;
    @(negedge clk);
    chk("key_err", key_err, {127'd0, !ok_exp});
    chk("aes_key", aes_key, key_model);
    @(negedge clk);
    chk("key_err_pulse_end", key_err, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_decrypt", aes_decrypt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_sector_done", sector_done, 0);
    chk("rst_aes_text", aes_text, 0);
    chk("rst_aes_key", aes_key, 0);
    chk("rst_out_data", out_data, 0);
  endtask

  initial begin
    logic [127:0] s1, s2, r1;
    bit any_valid;

    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single block: plaintext bytes FF, FE, ... F0
    core_lat = 50;
    send_block(128'h000102030405060708090a0b0c0d0e0f, 1'b1);
    drain();
    chk("dec_cnt_single", dec_cnt, 1);

    // Backpressure with gapped input
    toggle = 1'b1;
    gap = 1'b1;
    send_block(128'h112233445566778899aabbccddeeff00, 1'b1);
    drain();
    toggle = 1'b0;
    gap = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Key rules
    do_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b1);
    push_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1);
    send_range(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 0, 4);
    do_key(128'hdeadbeef00000000cafef00d12345678, 1'b0);
    send_range(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 5, 15);
    repeat (3) @(posedge clk);
    #1;
    do_key(128'h0123456789abcdeffedcba9876543210, 1'b0);
    drain();

    // Stale done level carried into the next WAIT
    core_auto = 1'b0;
    s1 = 128'ha0a1a2a3a4a5a6a7a8a9aaabacadaeaf;
    s2 = 128'h5051525354555657c8c9cacbcccdcecf;
    send_block(s1, 1'b1);
    wait_dec();
    repeat (5) @(posedge clk);
    #1;
    aes_dout = ~s1;
    aes_done = 1'b1;
    drain();
    send_block(s2, 1'b1);
    wait_dec();
    aes_dout = '0;
    any_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) any_valid = 1'b1;
    end
    chk("stale_no_capture", any_valid, 0);
    @(posedge clk);
    #1;
    aes_done = 1'b0;
    @(posedge clk);
    #1;
    aes_dout = ~s2;
    aes_done = 1'b1;
    @(posedge clk);
    #1;
    aes_done = 1'b0;
    drain();

    // Reset mid-WAIT, then a late core completion
    r1 = 128'h99887766554433221100ffeeddccbbaa;
    send_block(r1, 1'b0);
    wait_dec();
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_model = '0;
    aes_dout = ~r1;
    aes_done = 1'b1;
    @(posedge clk);
    #1;
    aes_done = 1'b0;
    any_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || busy) any_valid = 1'b1;
    end
    chk("late_done_ignored", any_valid, 0);
    chk("after_reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    core_auto = 1'b1;
    core_lat = 7;
    send_block(128'h13579bdf2468ace0fedcba9876543210, 1'b1);
    drain();

    // Full sector of 32 blocks
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    key_model = '0;
    sec_bytes = 0;
    sd_cnt = 0;
    dec_cnt = 0;
    core_lat = 3;
    for (int b = 0; b < BPS; b++) send_block(mk_block(8'(b * 16)), 1'b1);
    drain();
    chk("sector_done_count", sd_cnt, 1);
    chk("sector_decrypts", dec_cnt, BPS);
    chk("sector_bytes", sec_bytes, 512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
